// File: rtl/pled_fade_sequencer.sv
// rtl/pled_fade_sequencer.sv - PWM LED fade sequencer for the Pmod PowerLED
//
// Purpose: owns a free-running PWM counter, a step-rate prescaler and one duty
// register per LED channel. On start it ramps each channel in turn up to
// max_level, holds for hold_steps+1 steps, ramps back to zero, then moves on to
// the next channel, optionally looping back to channel 0.
//
// Ports:
//   clk, rst_n      - system clock, asynchronous active-low reset
//   start, stop     - one-cycle command pulses (stop has priority)
//   max_level       - peak duty, latched on accepted start
//   hold_steps      - hold length in steps minus one, latched on accepted start
//   repeat_en       - loop after last channel, latched on accepted start
//   led_out         - registered PWM outputs, one per channel
//   busy, done      - sequence running / one-cycle completion pulse
//   active_ch       - channel currently being faded
//   pwm_counter     - debug view of the PWM counter
//   step_tick       - debug view of the prescaler tick

module pled_fade_sequencer #(
    parameter int CHANNELS = 4,
    parameter int PWM_BITS = 4,
    parameter int TICK_DIV = 4096,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic [PWM_BITS-1:0] max_level,
    input  logic [7:0]          hold_steps,
    input  logic                repeat_en,
    output logic [CHANNELS-1:0] led_out,
    output logic                busy,
    output logic                done,
    output logic [CH_W-1:0]     active_ch,
    output logic [PWM_BITS-1:0] pwm_counter,
    output logic                step_tick
);

    localparam int DIV_W = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_UP   = 3'd1,
        S_HOLD = 3'd2,
        S_DOWN = 3'd3,
        S_NEXT = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [PWM_BITS-1:0]   pwm_q, pwm_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [PWM_BITS-1:0]   duty_q [CHANNELS];
    logic [PWM_BITS-1:0]   duty_d [CHANNELS];
    logic [CH_W-1:0]       active_q, active_d;
    logic [7:0]            hold_cnt_q, hold_cnt_d;
    logic [PWM_BITS-1:0]   max_q, max_d;
    logic [7:0]            hold_steps_q, hold_steps_d;
    logic                  repeat_q, repeat_d;
    logic [CHANNELS-1:0]   led_q, led_d;
    logic                  done_q, done_d;
    logic                  tick;

    assign tick = (state_q != S_IDLE) && (div_q == DIV_W'(TICK_DIV - 1));

    always_comb begin
        state_d      = state_q;
        pwm_d        = pwm_q + PWM_BITS'(1);
        active_d     = active_q;
        hold_cnt_d   = hold_cnt_q;
        max_d        = max_q;
        hold_steps_d = hold_steps_q;
        repeat_d     = repeat_q;
        done_d       = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            duty_d[c] = duty_q[c];
            led_d[c]  = (pwm_q < duty_q[c]);
        end

        if (stop) begin
            state_d    = S_IDLE;
            active_d   = '0;
            hold_cnt_d = '0;
            for (int c = 0; c < CHANNELS; c++) duty_d[c] = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        max_d        = max_level;
                        hold_steps_d = hold_steps;
                        repeat_d     = repeat_en;
                        active_d     = '0;
                        for (int c = 0; c < CHANNELS; c++) duty_d[c] = '0;
                        state_d      = S_UP;
                    end
                end
                S_UP: begin
                    if (tick) begin
                        if (duty_q[active_q] == max_q) begin
                            hold_cnt_d = '0;
                            state_d    = S_HOLD;
                        end else begin
                            duty_d[active_q] = duty_q[active_q] + PWM_BITS'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (tick) begin
                        if (hold_cnt_q == hold_steps_q) state_d = S_DOWN;
                        else hold_cnt_d = hold_cnt_q + 8'd1;
                    end
                end
                S_DOWN: begin
                    if (tick) begin
                        if (duty_q[active_q] == '0) state_d = S_NEXT;
                        else duty_d[active_q] = duty_q[active_q] - PWM_BITS'(1);
                    end
                end
                S_NEXT: begin
                    // Single-cycle hop between channels; the prescaler keeps
                    // running so tick spacing stays uniform.
                    if (active_q < CH_W'(CHANNELS - 1)) begin
                        active_d = active_q + CH_W'(1);
                        state_d  = S_UP;
                    end else if (repeat_q) begin
                        active_d = '0;
                        state_d  = S_UP;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Prescaler restarts from zero on an accepted start and rests at zero
        // whenever the sequencer is (or is about to be) idle.
        if (state_q == S_IDLE || state_d == S_IDLE) div_d = '0;
        else if (div_q == DIV_W'(TICK_DIV - 1)) div_d = '0;
        else div_d = div_q + DIV_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pwm_q        <= '0;
            div_q        <= '0;
            active_q     <= '0;
            hold_cnt_q   <= '0;
            max_q        <= '0;
            hold_steps_q <= '0;
            repeat_q     <= 1'b0;
            led_q        <= '0;
            done_q       <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) duty_q[c] <= '0;
        end else begin
            state_q      <= state_d;
            pwm_q        <= pwm_d;
            div_q        <= div_d;
            active_q     <= active_d;
            hold_cnt_q   <= hold_cnt_d;
            max_q        <= max_d;
            hold_steps_q <= hold_steps_d;
            repeat_q     <= repeat_d;
            led_q        <= led_d;
            done_q       <= done_d;
            for (int c = 0; c < CHANNELS; c++) duty_q[c] <= duty_d[c];
        end
    end

    assign led_out     = led_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign active_ch   = active_q;
    assign pwm_counter = pwm_q;
    assign step_tick   = tick;

endmodule

// File: tb/tb_pled_fade_sequencer.sv
// tb/tb_pled_fade_sequencer.sv - directed self-checking bench for pled_fade_sequencer

module tb_pled_fade_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] max_level = 4'd0;
    logic [7:0] hold_steps = 8'd0;
    logic       repeat_en = 1'b0;
    logic [1:0] led_out;
    logic       busy;
    logic       done;
    logic [0:0] active_ch;
    logic [3:0] pwm_counter;
    logic       step_tick;

    int passed = 0;
    int total  = 0;
    int e      = 0;
    int cyc    = 0;

    pled_fade_sequencer #(
        .CHANNELS(2),
        .PWM_BITS(4),
        .TICK_DIV(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .stop(stop),
        .max_level(max_level),
        .hold_steps(hold_steps),
        .repeat_en(repeat_en),
        .led_out(led_out),
        .busy(busy),
        .done(done),
        .active_ch(active_ch),
        .pwm_counter(pwm_counter),
        .step_tick(step_tick)
    );

    always #5 clk = ~clk;

    // Reference count of clock edges since reset; the PWM counter must track it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic goto_edge(input int k);
        adv(k - e);
        e = k;
    endtask

    task automatic do_start(input logic [3:0] m, input logic [7:0] h, input logic r);
        max_level  = m;
        hold_steps = h;
        repeat_en  = r;
        start      = 1'b1;
        adv(1);
        start = 1'b0;
        e     = 0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        adv(1);
        stop = 1'b0;
    endtask

    int cnt;
    int dcnt;
    logic exp_led;

    initial begin
        // Reset values
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_led", led_out, 0);
        chk("rst_ch", active_ch, 0);
        chk("rst_pwm", pwm_counter, 0);
        chk("rst_tick", step_tick, 0);
        #19 rst_n = 1'b1;
        adv(1);

        // Single pass: M=2, H=1, no repeat
        do_start(4'd2, 8'd1, 1'b0);
        chk("sp_busy0", busy, 1);
        chk("sp_ch0", active_ch, 0);
        chk("sp_pwm", pwm_counter, cyc[3:0]);
        goto_edge(3);  chk("sp_tick3", step_tick, 1);
        goto_edge(4);  chk("sp_duty4", dut.duty_q[0], 1); chk("sp_tick4", step_tick, 0);
        goto_edge(8);  chk("sp_duty8", dut.duty_q[0], 2);
        goto_edge(12); chk("sp_duty12", dut.duty_q[0], 2);
        goto_edge(16); chk("sp_duty16", dut.duty_q[0], 2);
        goto_edge(20); chk("sp_duty20", dut.duty_q[0], 2);
        goto_edge(24); chk("sp_duty24", dut.duty_q[0], 1);
        goto_edge(28); chk("sp_duty28", dut.duty_q[0], 0);
        goto_edge(32); chk("sp_ch32", active_ch, 0); chk("sp_busy32", busy, 1);
        goto_edge(33); chk("sp_ch33", active_ch, 1);
        goto_edge(37); chk("sp_d1_37", dut.duty_q[1], 1); chk("sp_d0_37", dut.duty_q[0], 0);
        goto_edge(64); chk("sp_busy64", busy, 1); chk("sp_done64", done, 0);
        goto_edge(65); chk("sp_busy65", busy, 0); chk("sp_done65", done, 1);
        goto_edge(66); chk("sp_done66", done, 0);

        // PWM shape, duty 3
        do_start(4'd3, 8'd200, 1'b0);
        goto_edge(20);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            adv(1);
            exp_led = (((cyc - 1) & 15) < 3);
            chk("pwm3_bit", led_out[0], exp_led);
            chk("pwm3_cnt", pwm_counter, cyc[3:0]);
            if (led_out[0]) cnt++;
        end
        chk("pwm3_high", cnt, 3);
        do_stop();

        // PWM shape, duty 15
        do_start(4'd15, 8'd200, 1'b0);
        goto_edge(70);
        chk("pwm15_duty", dut.duty_q[0], 15);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            adv(1);
            if (led_out[0]) cnt++;
            chk("pwm15_ch1", led_out[1], 0);
        end
        chk("pwm15_high", cnt, 15);
        do_stop();
        adv(1);

        // Repeat: M=1, H=0 -> 20 cycles per channel
        do_start(4'd1, 8'd0, 1'b1);
        dcnt = 0;
        for (int k = 1; k <= 70; k++) begin
            goto_edge(k);
            if (done) dcnt++;
            if (k == 10) chk("rep_ch10", active_ch, 0);
            if (k == 30) chk("rep_ch30", active_ch, 1);
            if (k == 50) chk("rep_ch50", active_ch, 0);
            if (k == 70) chk("rep_ch70", active_ch, 1);
        end
        chk("rep_nodone", dcnt, 0);
        chk("rep_duty70", dut.duty_q[1], 1);
        stop = 1'b1;
        goto_edge(71);
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_done", done, 0);
        chk("stop_ch", active_ch, 0);
        chk("stop_duty", dut.duty_q[1], 0);
        goto_edge(72);
        chk("stop_led", led_out, 0);
        chk("stop_done2", done, 0);

        // Start while busy with new config is ignored
        do_start(4'd2, 8'd1, 1'b0);
        goto_edge(10);
        max_level = 4'd15; hold_steps = 8'd0; repeat_en = 1'b1; start = 1'b1;
        goto_edge(11);
        start = 1'b0;
        chk("ign_tick11", step_tick, 1);
        goto_edge(16); chk("ign_duty16", dut.duty_q[0], 2);
        goto_edge(24); chk("ign_duty24", dut.duty_q[0], 1);
        goto_edge(65); chk("ign_done65", done, 1); chk("ign_busy65", busy, 0);

        // max_level = 0: H+3 = 4 ticks per channel, LED dark
        do_start(4'd0, 8'd1, 1'b0);
        cnt = 0;
        for (int k = 1; k <= 33; k++) begin
            goto_edge(k);
            if (led_out != 2'b00) cnt++;
            if (k == 16) chk("m0_ch16", active_ch, 0);
            if (k == 17) chk("m0_ch17", active_ch, 1);
            if (k == 32) chk("m0_done32", done, 0);
        end
        chk("m0_dark", cnt, 0);
        chk("m0_done33", done, 1);

        // stop and start together while idle
        stop = 1'b1; start = 1'b1;
        adv(1);
        stop = 1'b0; start = 1'b0;
        chk("ss_busy1", busy, 0);
        adv(1);
        chk("ss_busy2", busy, 0);

        // Asynchronous reset mid-run
        do_start(4'd2, 8'd1, 1'b0);
        goto_edge(10);
        chk("ar_busy_pre", busy, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_led", led_out, 0);
        chk("ar_ch", active_ch, 0);
        chk("ar_pwm", pwm_counter, 0);
        chk("ar_tick", step_tick, 0);
        chk("ar_done", done, 0);
        chk("ar_duty", dut.duty_q[0], 0);
        #10 rst_n = 1'b1;
        adv(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pled_fade_sequencer.md
# pled_fade_sequencer

Sequencer that owns the Pmod PowerLED PWM datapath: a free-running PWM counter, a step-rate prescaler and per-channel duty registers. On command it fades each LED channel in turn up to a programmed level, holds, fades back down, then moves to the next channel, optionally looping. It sits between the board control logic (buttons or a host) and the LED pads. The PWM counter and step tick are exported so the on-chip analyzer can probe them.

## Interface
- `CHANNELS`, 4: number of LED channels; must be ≥1.
- `PWM_BITS`, 4: PWM counter and duty width.
- `TICK_DIV`, 4096: clock cycles per fade step; must be ≥2.
- `clk` in 1: single system clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; begins a sequence when idle.
- `stop` in 1: one-cycle pulse; aborts any sequence.
- `max_level` in PWM_BITS: peak duty; sampled on accepted `start`.
- `hold_steps` in 8: hold length in steps, minus one; sampled on accepted `start`.
- `repeat_en` in 1: loop back to channel 0 after the last channel; sampled on accepted `start`.
- `led_out` out CHANNELS: registered PWM outputs.
- `busy` out 1: high when the state is not IDLE.
- `done` out 1: one-cycle pulse at normal sequence completion.
- `active_ch` out clog2(CHANNELS) (min 1): channel being faded.
- `pwm_counter` out PWM_BITS: debug view of the PWM counter.
- `step_tick` out 1: debug view of the prescaler tick.

## Operation
- PWM counter: increments every clock in all states; wraps from 2^PWM_BITS−1 to 0.
- Output compare: `led_out[c]` is registered as (pwm_counter < duty[c]), unsigned.
  - Duty 0 gives constant low.
  - Duty 2^PWM_BITS−1 gives low for 1 cycle of each 2^PWM_BITS.
- Prescaler (`div_cnt`):
  - Cleared to 0 on an accepted `start`. Held at 0 in IDLE.
  - Otherwise counts 0..TICK_DIV−1 and wraps.
  - `step_tick` = busy && div_cnt == TICK_DIV−1 (combinational).
- States: IDLE, UP, HOLD, DOWN, NEXT.
- IDLE: on `start`, latch the config, set `active_ch`=0, clear all duties, go to UP.
- UP, on `step_tick`:
  - If duty == max_level, clear hold_cnt and go to HOLD.
  - Otherwise increment duty.
- HOLD, on `step_tick`: if hold_cnt == hold_steps, go to DOWN; otherwise increment hold_cnt.
- DOWN, on `step_tick`: if duty == 0, go to NEXT; otherwise decrement duty.
- NEXT lasts one cycle and does not consume a tick:
  - If active_ch < CHANNELS−1: increment active_ch and go to UP.
  - If it is the last channel and repeat_en is set: set active_ch=0 and go to UP.
  - If it is the last channel and repeat_en is clear: go to IDLE and pulse `done`.
- Only `duty[active_ch]` changes. All other channels stay at 0.
- Priority: `stop` > `step_tick`/state advance > `start`.
  - `stop` in any state: next cycle IDLE, all duties 0, `active_ch`=0, no `done`.
  - `start` while busy is ignored. Config changes while busy are ignored.
- max_level=0: UP exits on the first tick and the LED stays dark.

## Timing
- Reset values: state IDLE, duties 0, pwm_counter 0, div_cnt 0, `led_out` 0, `busy` 0, `done` 0, `active_ch` 0, `step_tick` 0.
- Edge numbering: `start` sampled at edge 0; `busy`=1 from edge 0. The k-th tick is consumed at edge k·TICK_DIV.
- Ticks per channel, with M=max_level and H=hold_steps: (M+1) + (H+1) + (M+1) = 2M+H+3.
- NEXT falls between ticks, so tick spacing stays uniform across channels.
- The final DOWN tick at edge T moves the state to NEXT. At edge T+1: `busy`=0 and `done`=1 for exactly one cycle.
- `led_out` lags pwm_counter and duty by one cycle.
- `stop` at edge E: `busy`=0 and all duties 0 after E. `led_out` is all 0 after E+1.

## Test plan
- Reset mid-run (CHANNELS=2, TICK_DIV=4): assert `rst_n`=0 asynchronously while busy → all outputs take their reset values immediately, before the next clock edge.
- Single pass (CHANNELS=2, TICK_DIV=4, M=2, H=1, repeat off): `start` at edge 0 →
  - `active_ch`=0 until edge 32; NEXT at edge 32; `active_ch`=1 from edge 33.
  - NEXT again at edge 64; `done` pulse and `busy`=0 after edge 65.
  - duty[0] follows 1, 2 at edges 4, 8; holds through edges 12–20; then 1, 0.
- PWM shape: force duty 3 (M=3, hold) → `led_out[0]` high 3 of every 16 cycles, one cycle after pwm_counter values 0..2. Duty 15 → low exactly 1 of 16.
- Repeat: M=1, H=0, repeat on, CHANNELS=2 → `active_ch` cycles 0, 1, 0, …; no `done`. Then `stop` → IDLE next cycle, no `done`, `led_out`=0 within 2 cycles.
- Corner cases:
  - `start` while busy → ignored, and config changes made then do not take effect.
  - max_level=0 → `led_out` stays 0 and each channel takes H+3 ticks.
  - `stop` and `start` in the same cycle while IDLE → stays IDLE.
